// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver state encoding, parity modes and default timing
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DONE
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD = 1;
    localparam int PAR_EVEN = 2;

    localparam int DEF_CLKS_PER_BIT = 217;

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchroniser for an asynchronous single-bit input
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // two back-to-back flops; both come out of reset at the line's idle level
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with glitch rejection, parity and stop-bit checks
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int DATA_BITS = 8,
    parameter int PARITY_MODE = PAR_NONE
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 rx_strobe,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam bit PAR_EN = (PARITY_MODE == PAR_ODD) || (PARITY_MODE == PAR_EVEN);
    localparam bit PAR_IS_ODD = (PARITY_MODE == PAR_ODD);

    logic rx_s;

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [CW-1:0]        count_q, count_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 armed_q, armed_d;
    logic                 par_pend_q, par_pend_d;
    logic                 rx_strobe_q, rx_strobe_d;
    logic [DATA_BITS-1:0] rx_byte_q, rx_byte_d;
    logic                 parity_error_q, parity_error_d;
    logic                 frame_error_q, frame_error_d;
    logic                 timer_end;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (rx),
        .q    (rx_s)
    );

    assign timer_end = (timer_q == TW'(CLKS_PER_BIT - 1));

    // next-state and datapath: frame walk from start-bit check through stop bit
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        shift_d = shift_q;
        armed_d = armed_q;
        par_pend_d = par_pend_q;
        rx_byte_d = rx_byte_q;
        parity_error_d = parity_error_q;
        frame_error_d = frame_error_q;
        case (state_q)
            IDLE: begin
                armed_d = armed_q | rx_s;
                if (armed_q && !rx_s) begin
                    state_d = START;
                    timer_d = '0;
                    par_pend_d = 1'b0;
                end
            end
            START: begin
                if (timer_q == TW'(HALF - 1)) begin
                    state_d = rx_s ? IDLE : DATA;
                    timer_d = '0;
                    count_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_end) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    count_d = count_q + CW'(1);
                    timer_d = '0;
                    if (count_q == CW'(DATA_BITS - 1)) state_d = PAR_EN ? PARITY : STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PARITY: begin
                if (timer_end) begin
                    par_pend_d = (^shift_q) ^ rx_s ^ PAR_IS_ODD;
                    state_d = STOP;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (timer_end) begin
                    state_d = DONE;
                    timer_d = '0;
                    armed_d = rx_s;
                    rx_byte_d = shift_q;
                    parity_error_d = par_pend_q;
                    frame_error_d = ~rx_s;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rx_strobe_d = (state_d == DONE);
    end

    // state and output registers; reset discards any frame in progress
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            count_q <= '0;
            shift_q <= '0;
            armed_q <= 1'b0;
            par_pend_q <= 1'b0;
            rx_strobe_q <= 1'b0;
            rx_byte_q <= '0;
            parity_error_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            shift_q <= shift_d;
            armed_q <= armed_d;
            par_pend_q <= par_pend_d;
            rx_strobe_q <= rx_strobe_d;
            rx_byte_q <= rx_byte_d;
            parity_error_q <= parity_error_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign rx_strobe = rx_strobe_q;
    assign rx_byte = rx_byte_q;
    assign parity_error = parity_error_q;
    assign frame_error = frame_error_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench over three receiver configurations
module tb_uart_rx_param;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx_l [3];

    logic       s0, pe0, fe0, bz0;
    logic [7:0] b0;
    logic       s1, pe1, fe1, bz1;
    logic [7:0] b1;
    logic       s2, pe2, fe2, bz2;
    logic [6:0] b2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    int n = 0;
    int errs = 0;
    int cyc = 0;
    int nstb [3];
    int last_stb [3];
    int t_start [3];

    uart_rx_param u0 (
        .clock(clock), .reset(reset), .rx(rx_l[0]), .rx_strobe(s0), .rx_byte(b0),
        .parity_error(pe0), .frame_error(fe0), .busy(bz0)
    );

    uart_rx_param #(.CLKS_PER_BIT(217), .DATA_BITS(8), .PARITY_MODE(2)) u1 (
        .clock(clock), .reset(reset), .rx(rx_l[1]), .rx_strobe(s1), .rx_byte(b1),
        .parity_error(pe1), .frame_error(fe1), .busy(bz1)
    );

    uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY_MODE(1)) u2 (
        .clock(clock), .reset(reset), .rx(rx_l[2]), .rx_strobe(s2), .rx_byte(b2),
        .parity_error(pe2), .frame_error(fe2), .busy(bz2)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic mon(input int u, input logic [8:0] d, input logic pe, input logic fe);
        exp_t e;
        int sz;
        sz = (u == 0) ? q0.size() : (u == 1) ? q1.size() : q2.size();
        nstb[u]++;
        last_stb[u] = cyc;
        chk($sformatf("u%0d strobe expected", u), 32'(sz > 0), 1);
        if (sz > 0) begin
            if (u == 0) e = q0.pop_front();
            else if (u == 1) e = q1.pop_front();
            else e = q2.pop_front();
            chk($sformatf("u%0d rx_byte", u), 32'(d), 32'(e.d));
            chk($sformatf("u%0d parity_error", u), 32'(pe), 32'(e.pe));
            chk($sformatf("u%0d frame_error", u), 32'(fe), 32'(e.fe));
        end
    endtask

    always @(negedge clock) begin
        if (s0) mon(0, {1'b0, b0}, pe0, fe0);
        if (s1) mon(1, {1'b0, b1}, pe1, fe1);
        if (s2) mon(2, {2'b0, b2}, pe2, fe2);
    end

    task automatic send_bit(input int u, input logic v, input int cycles);
        rx_l[u] = v;
        repeat (cycles) @(negedge clock);
    endtask

    task automatic frame(input int u, input int cpb, input int nb, input logic [8:0] d,
                         input int pb, input logic stp, input logic exp_pe);
        exp_t e;
        e = '{d: d, pe: exp_pe, fe: ~stp};
        if (u == 0) q0.push_back(e);
        else if (u == 1) q1.push_back(e);
        else q2.push_back(e);
        t_start[u] = cyc;
        send_bit(u, 1'b0, cpb);
        for (int i = 0; i < nb; i++) send_bit(u, d[i], cpb);
        if (pb >= 0) send_bit(u, pb[0], cpb);
        send_bit(u, stp, cpb);
        rx_l[u] = 1'b1;
    endtask

    initial begin
        #2000000;
        errs++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        for (int i = 0; i < 3; i++) begin
            rx_l[i] = 1'b1;
            nstb[i] = 0;
            last_stb[i] = 0;
            t_start[i] = 0;
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("reset rx_strobe", 32'(s0), 0);
        chk("reset rx_byte", 32'(b0), 0);
        chk("reset parity_error", 32'(pe0), 0);
        chk("reset frame_error", 32'(fe0), 0);
        chk("reset busy", 32'(bz0), 0);
        repeat (5) @(negedge clock);

        frame(0, 217, 8, 9'h0A5, -1, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        chk("A5 latency", 32'(last_stb[0] - t_start[0]), 2064);
        chk("A5 strobe count", 32'(nstb[0]), 1);

        frame(1, 217, 8, 9'h03C, 1, 1'b1, 1'b1);
        frame(1, 217, 8, 9'h03C, 0, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        chk("even parity strobe count", 32'(nstb[1]), 2);

        frame(0, 217, 8, 9'h055, -1, 1'b0, 1'b0);
        send_bit(0, 1'b0, 5 * 217);
        rx_l[0] = 1'b1;
        repeat (300) @(negedge clock);
        chk("break single strobe", 32'(nstb[0]), 2);
        frame(0, 217, 8, 9'h012, -1, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        chk("after break strobe count", 32'(nstb[0]), 3);

        busy_cnt = 0;
        rx_l[0] = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (i == 50) rx_l[0] = 1'b1;
            @(negedge clock);
            busy_cnt += int'(bz0);
        end
        chk("glitch busy within bound", 32'(busy_cnt >= 100 && busy_cnt <= 110), 1);
        chk("glitch no strobe", 32'(nstb[0]), 3);
        chk("glitch rx_byte held", 32'(b0), 32'h12);
        chk("glitch frame_error held", 32'(fe0), 0);

        send_bit(0, 1'b0, 217);
        for (int i = 0; i < 4; i++) send_bit(0, (i == 0), 217);
        send_bit(0, 1'b0, 100);
        reset = 1'b1;
        rx_l[0] = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("mid-frame reset rx_byte", 32'(b0), 0);
        chk("mid-frame reset busy", 32'(bz0), 0);
        chk("mid-frame reset frame_error", 32'(fe0), 0);
        chk("mid-frame reset parity_error", 32'(pe0), 0);
        chk("mid-frame reset rx_strobe", 32'(s0), 0);
        repeat (50) @(negedge clock);
        chk("mid-frame reset no strobe", 32'(nstb[0]), 3);
        frame(0, 217, 8, 9'h081, -1, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        chk("0x81 strobe count", 32'(nstb[0]), 4);

        frame(2, 16, 7, 9'h07F, 0, 1'b1, 1'b0);
        frame(2, 16, 7, 9'h000, 1, 1'b1, 1'b0);
        repeat (20) @(negedge clock);
        chk("7O1 back-to-back strobes", 32'(nstb[2]), 2);
        chk("7O1 second frame latency", 32'(last_stb[2] - t_start[2]), 155);

        chk("u0 scoreboard drained", 32'(q0.size()), 0);
        chk("u1 scoreboard drained", 32'(q1.size()), 0);
        chk("u2 scoreboard drained", 32'(q2.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n, errs);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver for the serial input path. It recovers 8N1 frames and also supports configurable baud divisor, data width and optional parity. It adds an input synchroniser, start-bit glitch rejection, stop-bit checking and per-frame error flags. It sits between the board RX pin and the byte-consuming logic, and emits a one-cycle strobe per received frame.

## Interface
- CLKS_PER_BIT, default 217: clock cycles per bit period; legal ≥ 4
- DATA_BITS, default 8: data bits per frame; legal 5–9
- PARITY_MODE, default 0: 0 = none, 1 = odd, 2 = even
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high
- rx  input  1  raw serial line; idles high; asynchronous to clock
- rx_strobe  output  1  one-cycle pulse; frame complete
- rx_byte  output  DATA_BITS  received data, LSB first on the line
- parity_error  output  1  parity mismatch on the last frame; 0 when PARITY_MODE = 0
- frame_error  output  1  stop bit sampled low on the last frame
- busy  output  1  high in any state other than IDLE

## Operation
- rx passes through a 2-FF synchroniser, giving rx_s. Both flops reset to 1.
- HALF = CLKS_PER_BIT/2 (floor). The bit timer counts 0..CLKS_PER_BIT-1. The bit counter counts 0..DATA_BITS.
- IDLE:
  - Unarmed until rx_s = 1 has been seen for at least one cycle. This prevents a held-low line (break) from retriggering.
  - When armed and rx_s = 0: go to START, timer = 0.
- START:
  - At timer = HALF-1, sample rx_s.
  - If rx_s = 1: glitch. Go to IDLE, no strobe, no output change.
  - Else: go to DATA, timer = 0, counter = 0.
- DATA:
  - At timer = CLKS_PER_BIT-1, shift rx_s into the MSB of the shift register (LSB-first assembly), counter+1, timer = 0.
  - After DATA_BITS samples: go to PARITY if PARITY_MODE ≠ 0, else STOP.
- PARITY:
  - Sample at timer = CLKS_PER_BIT-1.
  - Error when XOR(data, parity bit) ≠ 1 (odd mode) or ≠ 0 (even mode).
  - Then go to STOP.
- STOP:
  - Sample at timer = CLKS_PER_BIT-1. frame_error_next = ~rx_s.
  - Go to DONE. Disarm if rx_s = 0.
- DONE: one cycle, then IDLE.
- rx_byte, parity_error and frame_error load on the DONE-entry edge. They hold until the next frame's DONE entry.
- Frames with errors still strobe and still deliver data.
- Reset values: rx_strobe 0, rx_byte 0, parity_error 0, frame_error 0, busy 0. State is IDLE, unarmed until rx_s = 1 (true immediately, since the sync flops reset to 1).
- Reset mid-frame: the frame is discarded with no strobe, and all outputs return to their reset values.
- Unused PARITY_MODE value 3 behaves as 0.

## Timing
- rx_strobe is registered and asserts exactly during DONE. rx_byte and both error flags are valid in the same cycle.
- Timer width is $clog2(CLKS_PER_BIT). Counter width is $clog2(DATA_BITS+1). No overflow is possible in legal configurations.
- Sync latency: 2 cycles from rx edge to rx_s.
- Latency from the first cycle rx_s = 0 to the rx_strobe cycle is HALF + (DATA_BITS + P + 1)·CLKS_PER_BIT + 1 cycles, where P = 1 if parity is enabled, else 0.
  - Example, defaults: 108 + 9·217 + 1 = 2062.
- Back-to-back frames: a new start bit immediately after a good stop bit is detected. The detector is armed in IDLE the cycle after DONE, since the stop bit was high.
- busy is high from the START-entry cycle through DONE inclusive.

## Structure
- Shared package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, DONE)
  - parity-mode constants PAR_NONE = 0, PAR_ODD = 1, PAR_EVEN = 2
  - default CLKS_PER_BIT constant 217
- One sub-module, uart_rx_sync: 2-FF synchroniser with parametrised reset value. It is reusable by the future TX-loopback path.

## Test plan
- Defaults, send 0xA5 (8N1), stop high → one rx_strobe 2062 cycles after rx_s falls; rx_byte = 0xA5; both errors 0.
- PARITY_MODE = 2, send 0x3C with parity bit 1 → rx_byte = 0x3C, parity_error = 1. Resend with parity 0 → parity_error = 0.
- Send 0x55 with stop bit low, then hold rx low for 5 bit periods → frame_error = 1, single strobe. No further strobe until rx returns high and a new start bit arrives.
- Low pulse of 50 cycles on idle line (defaults) → no strobe, busy high for ≤ 110 cycles, outputs unchanged.
- Assert reset during data bit 4 of a frame → outputs zero, state IDLE. The next complete frame 0x81 is received correctly.
- DATA_BITS = 7, CLKS_PER_BIT = 16, odd parity: two back-to-back frames 0x7F and 0x00 with no idle gap → two strobes, correct bytes, parity_error = 0 both.
